mcdf_ctrl_regs: RTL and testbench
=================================

MCDF_CTRL_REGS -- requirements
Module: mcdf_ctrl_regs

Interface
REQ-001 SHALL use parameter: CHNL_NUM, 3, number of data channels.
REQ-002 SHALL use parameter: FIFO_DEPTH, 32, depth of each channel FIFO, used for status reporting.
REQ-003 SHALL use one clock and an asynchronous, active-low reset, with these ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rstn  input  1  asynchronous active-low reset.
REQ-004 SHALL provide the command bus:
- cmd_i  input  2  command: 00 IDLE, 10 WRITE, 01 READ, 11 reserved and treated as IDLE.
- cmd_addr_i  input  8  byte address of the register.
- cmd_data_i  input  32  write data.
- cmd_data_o  output  32  read data.
REQ-005 SHALL provide the channel status inputs:
- slv_margin_i  input  CHNL_NUM*8  free-slot count for each channel FIFO; channel n uses bits [8n+7:8n].
- chnl_busy_i  input  CHNL_NUM  channel n is mid-packet.
REQ-006 SHALL provide the channel configuration outputs:
- chnl_en_o  output  CHNL_NUM  effective channel enable; this is the signal the interface monitor samples.
- chnl_prio_o  output  CHNL_NUM*2  arbitration priority per channel; 0 is highest.
- chnl_len_o  output  CHNL_NUM*3  packet length code per channel.

Function
REQ-007 SHALL map control register n (R/W) to address 0x00+4n, for n = 0 to 2:
- bit0: en
- bits[2:1]: prio
- bits[5:3]: len
- bits[31:6]: reserved; read as 0 and ignore writes.
REQ-008 SHALL map status register n (RO) to address 0x10+4n:
- bits[7:0]: slv_margin for channel n.
- bits[8]: drain_pending for channel n.
- all other bits read as 0.
REQ-009 SHALL make writes take effect on the rising clk edge where cmd_i=WRITE; updated fields are visible on outputs the next cycle.
REQ-010 SHALL ignore writes to status addresses, unmapped addresses, and unaligned addresses (addr[1:0]≠0); these writes change no state.
REQ-011 SHALL register read data: cmd_data_o is valid in the cycle after the READ sample, giving 1-cycle latency.
REQ-012 SHALL return 0 in the following read cases:
- reads of unmapped or unaligned addresses;
- any cycle whose previous command was not READ.
REQ-013 SHALL, on a read of a status register, return slv_margin as sampled in the READ cycle.
REQ-014 SHALL apply the per-channel enable state machine, with states DISABLED, ENABLED and DRAINING; chnl_en_o=1 in ENABLED and DRAINING.
REQ-015 SHALL make these state transitions:
- DISABLED→ENABLED on a write with en=1.
- ENABLED→DISABLED on a write with en=0 while chnl_busy_i=0.
- ENABLED→DRAINING on a write with en=0 while chnl_busy_i=1.
- DRAINING→DISABLED on the first cycle chnl_busy_i=0.
- DRAINING→ENABLED on a write with en=1; this cancels the drain.
REQ-016 SHALL set drain_pending=1 exactly while a channel is in DRAINING.
REQ-017 SHALL, on a read of a control register, return the software-written en bit, not chnl_en_o.
REQ-018 SHALL, while a channel is in ENABLED or DRAINING, update prio and len on write, but hold chnl_prio_o and chnl_len_o until the channel's chnl_busy_i=0, so an in-flight packet is never reconfigured.
REQ-019 SHALL handle a WRITE and a chnl_busy_i falling edge in the same cycle as follows: the write is evaluated against the current-cycle chnl_busy_i value.
REQ-020 SHALL saturate a status slv_margin value greater than FIFO_DEPTH to FIFO_DEPTH.

Reset
REQ-021 SHALL, on rstn=0 (asynchronous), force every channel to DISABLED with en=0, prio=3 and len=0.
REQ-022 SHALL, on rstn=0, set cmd_data_o=0, chnl_en_o=0, chnl_prio_o all ones, and chnl_len_o=0.
REQ-023 SHALL abort any DRAINING state immediately on reset assertion mid-operation; drain_pending becomes 0.
REQ-024 SHALL deassert reset synchronously to clk in the environment; the block needs no internal synchronizer.

Structure
REQ-025 SHALL place the following in shared package mcdf_pkg, also used by the bench:
- cmd encodings IDLE, WRITE and READ;
- register address constants;
- field bit positions;
- the channel state enum.
REQ-026 SHALL implement one sub-module, mcdf_chnl_ctrl, instantiated CHNL_NUM times; it holds one channel's register fields, state machine and shadow/effective config.
REQ-027 SHALL contain address decode and the read mux in the top level only.

Verification
REQ-028 SHALL cover reset defaults: assert rstn=0 mid-simulation → next monitor sample shows chnl_en=0, prio=3, len=0 on all channels; reading 0x00 returns 0x6.
REQ-029 SHALL cover write/read: WRITE 0x04 with data 0x2B, then READ 0x04 → cmd_data_o=0x2B one cycle later; chnl_en_o[1]=1, prio[1]=1, len[1]=5.
REQ-030 SHALL cover drain: with chnl_busy_i[0]=1, WRITE 0x00 with 0x0 → chnl_en_o[0] stays 1 and READ 0x10 shows bit8=1; drop busy → chnl_en_o[0]=0 the next cycle and bit8=0.
REQ-031 SHALL cover drain cancel: while DRAINING, WRITE 0x00 with 0x1 → state ENABLED and chnl_en_o[0] remains 1 continuously.
REQ-032 SHALL cover illegal access: WRITE 0x10, 0x0C and 0x02 with 0xFFFFFFFF → all registers unchanged; READ 0x0C → 0.
REQ-033 SHALL cover status: drive slv_margin=0x20 (ch2) and 0x25 (ch0), then READ 0x18 and 0x10 → 0x20 and 0x20 (saturated).

Source files
------------

// File: rtl/mcdf_pkg.sv
// ----------------------------------------------------------------------------
// mcdf_pkg
// Shared definitions for the MCDF control/status register block and its bench:
// command encodings, register map, register field positions, the per-channel
// enable state enum and the status margin saturation helper.
// ----------------------------------------------------------------------------
package mcdf_pkg;

  // Command bus encodings (2'b11 is reserved and behaves as IDLE)
  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_READ  = 2'b01;

  // Register map: control register n at CTRL_BASE_ADDR + 4n,
  // status register n at STAT_BASE_ADDR + 4n
  localparam logic [7:0] CTRL_BASE_ADDR = 8'h00;
  localparam logic [7:0] STAT_BASE_ADDR = 8'h10;
  localparam int         ADDR_STRIDE    = 4;

  // Control register fields
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_PRIO_LSB = 1;
  localparam int CTRL_PRIO_W   = 2;
  localparam int CTRL_LEN_LSB  = 3;
  localparam int CTRL_LEN_W    = 3;
  localparam int CTRL_FIELD_W  = 6;

  // Status register fields
  localparam int STAT_MARGIN_LSB = 0;
  localparam int STAT_MARGIN_W   = 8;
  localparam int STAT_DRAIN_BIT  = 8;

  // Reset value of the priority field (lowest priority)
  localparam logic [1:0] PRIO_RESET = 2'b11;

  // Per-channel enable state
  typedef enum logic [1:0] {
    CH_DISABLED = 2'b00,
    CH_ENABLED  = 2'b01,
    CH_DRAINING = 2'b10
  } chnl_state_e;

  // Clamp a reported free-slot count to the physical FIFO depth
  function automatic logic [7:0] sat_margin(input logic [7:0] margin,
                                            input logic [7:0] depth);
    return (margin > depth) ? depth : margin;
  endfunction

endpackage

// File: rtl/mcdf_ctrl_regs_if.sv
// ----------------------------------------------------------------------------
// mcdf_ctrl_regs_if
// Command bus between a register master and the MCDF register block.
//   cmd_i       2   command (IDLE / WRITE / READ)
//   cmd_addr_i  8   byte address
//   cmd_data_i  32  write data
//   cmd_data_o  32  registered read data (1-cycle latency)
// The master modport drives the command; the slave modport returns read data.
// ----------------------------------------------------------------------------
interface mcdf_ctrl_regs_if;
  logic [1:0]  cmd_i;
  logic [7:0]  cmd_addr_i;
  logic [31:0] cmd_data_i;
  logic [31:0] cmd_data_o;

  modport master (
    output cmd_i, cmd_addr_i, cmd_data_i,
    input  cmd_data_o
  );

  modport slave (
    input  cmd_i, cmd_addr_i, cmd_data_i,
    output cmd_data_o
  );
endinterface

// File: rtl/mcdf_chnl_ctrl.sv
// ----------------------------------------------------------------------------
// mcdf_chnl_ctrl
// One channel's control register, enable state machine and the effective
// (packet-safe) copy of prio/len driven to the channel.
//   clk, rstn          clock, asynchronous active-low reset
//   i_wr_en            write strobe for this channel's control register
//   i_wr_data[5:0]     control field bits of the write data
//   i_busy             channel is mid-packet
//   o_en               effective enable (ENABLED or DRAINING)
//   o_drain_pending    channel is in DRAINING
//   o_prio, o_len      effective priority / length code
//   o_ctrl_rd[5:0]     software view of the control fields for read-back
// ----------------------------------------------------------------------------
module mcdf_chnl_ctrl
  import mcdf_pkg::*;
(
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_wr_en,
  input  logic [CTRL_FIELD_W-1:0] i_wr_data,
  input  logic                    i_busy,
  output logic                    o_en,
  output logic                    o_drain_pending,
  output logic [CTRL_PRIO_W-1:0]  o_prio,
  output logic [CTRL_LEN_W-1:0]   o_len,
  output logic [CTRL_FIELD_W-1:0] o_ctrl_rd
);

  logic                   r_sw_en;
  logic [CTRL_PRIO_W-1:0] r_sw_prio;
  logic [CTRL_LEN_W-1:0]  r_sw_len;
  logic [CTRL_PRIO_W-1:0] r_eff_prio;
  logic [CTRL_LEN_W-1:0]  r_eff_len;
  chnl_state_e            r_state;
  chnl_state_e            w_state_next;

  logic                   w_wr_en_bit;
  logic [CTRL_PRIO_W-1:0] w_prio_next;
  logic [CTRL_LEN_W-1:0]  w_len_next;
  logic                   w_cfg_open;

  assign w_wr_en_bit = i_wr_data[CTRL_EN_BIT];
  assign w_prio_next = i_wr_en ? i_wr_data[CTRL_PRIO_LSB +: CTRL_PRIO_W] : r_sw_prio;
  assign w_len_next  = i_wr_en ? i_wr_data[CTRL_LEN_LSB +: CTRL_LEN_W]   : r_sw_len;

  // The effective config may only move while no packet is in flight; a
  // disabled channel has nothing to protect.
  assign w_cfg_open = (r_state == CH_DISABLED) || !i_busy;

  // A write is evaluated against this cycle's busy, so a write coinciding with
  // busy falling sees busy=1 and a same-cycle en=1 write wins over drain exit.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      CH_DISABLED: if (i_wr_en && w_wr_en_bit) w_state_next = CH_ENABLED;
      CH_ENABLED:  if (i_wr_en && !w_wr_en_bit)
                     w_state_next = i_busy ? CH_DRAINING : CH_DISABLED;
      CH_DRAINING: if (i_wr_en && w_wr_en_bit) w_state_next = CH_ENABLED;
                   else if (!i_busy)           w_state_next = CH_DISABLED;
      default:     w_state_next = CH_DISABLED;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= CH_DISABLED;
      r_sw_en    <= 1'b0;
      r_sw_prio  <= PRIO_RESET;
      r_sw_len   <= '0;
      r_eff_prio <= PRIO_RESET;
      r_eff_len  <= '0;
    end else begin
      r_state <= w_state_next;
      if (i_wr_en) begin
        r_sw_en   <= w_wr_en_bit;
        r_sw_prio <= w_prio_next;
        r_sw_len  <= w_len_next;
      end
      if (w_cfg_open) begin
        r_eff_prio <= w_prio_next;
        r_eff_len  <= w_len_next;
      end
    end
  end

  assign o_en            = (r_state != CH_DISABLED);
  assign o_drain_pending = (r_state == CH_DRAINING);
  assign o_prio          = r_eff_prio;
  assign o_len           = r_eff_len;
  assign o_ctrl_rd       = {r_sw_len, r_sw_prio, r_sw_en};

endmodule

// File: rtl/mcdf_ctrl_regs.sv
// ----------------------------------------------------------------------------
// mcdf_ctrl_regs
// MCDF control/status register block: address decode, per-channel control
// instances and the registered read mux.
//   clk, rstn       clock, asynchronous active-low reset
//   bus             command bus (slave side)
//   slv_margin_i    per-channel FIFO free-slot count, 8 bits per channel
//   chnl_busy_i     per-channel mid-packet flag
//   chnl_en_o       per-channel effective enable
//   chnl_prio_o     per-channel priority, 2 bits per channel (0 highest)
//   chnl_len_o      per-channel packet length code, 3 bits per channel
// ----------------------------------------------------------------------------
module mcdf_ctrl_regs
  import mcdf_pkg::*;
#(
  parameter int CHNL_NUM   = 3,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  mcdf_ctrl_regs_if.slave       bus,
  input  logic [CHNL_NUM*8-1:0] slv_margin_i,
  input  logic [CHNL_NUM-1:0]   chnl_busy_i,
  output logic [CHNL_NUM-1:0]   chnl_en_o,
  output logic [CHNL_NUM*2-1:0] chnl_prio_o,
  output logic [CHNL_NUM*3-1:0] chnl_len_o
);

  logic                    w_is_write;
  logic [CHNL_NUM-1:0]     w_wr_sel;
  logic [CHNL_NUM-1:0]     w_drain;
  logic [CTRL_FIELD_W-1:0] w_ctrl_rd [CHNL_NUM];
  logic [31:0]             w_rd_data;
  logic [31:0]             r_rd_data;
  logic                    w_unused;

  // Reserved write-data bits carry no state
  assign w_unused   = ^bus.cmd_data_i[31:CTRL_FIELD_W];
  assign w_is_write = (bus.cmd_i == CMD_WRITE);

  generate
    for (genvar gi = 0; gi < CHNL_NUM; gi++) begin : g_chnl
      localparam logic [7:0] CTRL_ADDR = CTRL_BASE_ADDR + 8'(ADDR_STRIDE * gi);

      // Exact match rejects unaligned, status and unmapped addresses
      assign w_wr_sel[gi] = w_is_write && (bus.cmd_addr_i == CTRL_ADDR);

      mcdf_chnl_ctrl u_chnl (
        .clk             (clk),
        .rstn            (rstn),
        .i_wr_en         (w_wr_sel[gi]),
        .i_wr_data       (bus.cmd_data_i[CTRL_FIELD_W-1:0]),
        .i_busy          (chnl_busy_i[gi]),
        .o_en            (chnl_en_o[gi]),
        .o_drain_pending (w_drain[gi]),
        .o_prio          (chnl_prio_o[gi*2 +: 2]),
        .o_len           (chnl_len_o[gi*3 +: 3]),
        .o_ctrl_rd       (w_ctrl_rd[gi])
      );
    end
  endgenerate

  // Read mux: anything not matching a register reads as zero
  always_comb begin
    w_rd_data = '0;
    for (int n = 0; n < CHNL_NUM; n++) begin
      if (bus.cmd_addr_i == CTRL_BASE_ADDR + 8'(ADDR_STRIDE * n))
        w_rd_data = 32'(w_ctrl_rd[n]);
      if (bus.cmd_addr_i == STAT_BASE_ADDR + 8'(ADDR_STRIDE * n)) begin
        w_rd_data[STAT_MARGIN_LSB +: STAT_MARGIN_W] =
          sat_margin(slv_margin_i[n*8 +: 8], 8'(FIFO_DEPTH));
        w_rd_data[STAT_DRAIN_BIT] = w_drain[n];
      end
    end
  end

  // Read data holds only for the cycle after a READ; otherwise returns zero
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      r_rd_data <= '0;
    else
      r_rd_data <= (bus.cmd_i == CMD_READ) ? w_rd_data : '0;
  end

  assign bus.cmd_data_o = r_rd_data;

endmodule

// File: tb/tb_mcdf_ctrl_regs.sv
// ----------------------------------------------------------------------------
// tb_mcdf_ctrl_regs
// Self-checking bench for mcdf_ctrl_regs: directed scenarios with literal
// expectations followed by randomized traffic against a behavioural model.
// ----------------------------------------------------------------------------
module tb_mcdf_ctrl_regs;
  import mcdf_pkg::*;

  localparam int CHNL_NUM   = 3;
  localparam int FIFO_DEPTH = 32;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic [CHNL_NUM*8-1:0] slv_margin;
  logic [CHNL_NUM-1:0]   chnl_busy;
  logic [CHNL_NUM-1:0]   chnl_en;
  logic [CHNL_NUM*2-1:0] chnl_prio;
  logic [CHNL_NUM*3-1:0] chnl_len;

  mcdf_ctrl_regs_if bus_if();

  mcdf_ctrl_regs #(.CHNL_NUM(CHNL_NUM), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .bus          (bus_if),
    .slv_margin_i (slv_margin),
    .chnl_busy_i  (chnl_busy),
    .chnl_en_o    (chnl_en),
    .chnl_prio_o  (chnl_prio),
    .chnl_len_o   (chnl_len)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model: "on" = channel output enabled, "drain" = waiting for
  // the in-flight packet before switching off.
  bit          m_on      [CHNL_NUM];
  bit          m_drain   [CHNL_NUM];
  bit          m_sw_en   [CHNL_NUM];
  int          m_sw_prio [CHNL_NUM];
  int          m_sw_len  [CHNL_NUM];
  int          m_out_prio[CHNL_NUM];
  int          m_out_len [CHNL_NUM];
  logic [31:0] m_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < CHNL_NUM; ch++) begin
      m_on[ch] = 0; m_drain[ch] = 0; m_sw_en[ch] = 0;
      m_sw_prio[ch] = 3; m_sw_len[ch] = 0;
      m_out_prio[ch] = 3; m_out_len[ch] = 0;
    end
    m_rdata = 32'h0;
  endtask

  function automatic logic [31:0] model_read(input logic [7:0] addr);
    int a;
    int ch;
    int m;
    a = int'(addr);
    if (a % 4 != 0) return 32'h0;
    if (a < 4 * CHNL_NUM) begin
      ch = a / 4;
      return 32'(m_sw_en[ch]) | (32'(m_sw_prio[ch]) << 1) | (32'(m_sw_len[ch]) << 3);
    end
    if (a >= 16 && a < 16 + 4 * CHNL_NUM) begin
      ch = (a - 16) / 4;
      m = int'(slv_margin[ch*8 +: 8]);
      if (m > FIFO_DEPTH) m = FIFO_DEPTH;
      return 32'(m) + (m_drain[ch] ? 32'd256 : 32'd0);
    end
    return 32'h0;
  endfunction

  task automatic model_step();
    bit wr;
    bit busy;
    bit was_on;
    bit en;
    m_rdata = (bus_if.cmd_i == CMD_READ) ? model_read(bus_if.cmd_addr_i) : 32'h0;
    for (int ch = 0; ch < CHNL_NUM; ch++) begin
      wr     = (bus_if.cmd_i == CMD_WRITE) && (int'(bus_if.cmd_addr_i) == 4 * ch);
      busy   = chnl_busy[ch];
      was_on = m_on[ch];
      en     = bus_if.cmd_data_i[0];
      if (wr) begin
        m_sw_en[ch]   = en;
        m_sw_prio[ch] = int'(bus_if.cmd_data_i[2:1]);
        m_sw_len[ch]  = int'(bus_if.cmd_data_i[5:3]);
      end
      if (!m_on[ch]) begin
        if (wr && en) m_on[ch] = 1;
      end else if (wr && en) begin
        m_drain[ch] = 0;
      end else if (wr) begin
        if (busy) m_drain[ch] = 1;
        else begin m_on[ch] = 0; m_drain[ch] = 0; end
      end else if (m_drain[ch] && !busy) begin
        m_on[ch] = 0; m_drain[ch] = 0;
      end
      if (!was_on || !busy) begin
        m_out_prio[ch] = m_sw_prio[ch];
        m_out_len[ch]  = m_sw_len[ch];
      end
    end
  endtask

  task automatic compare_all();
    logic [CHNL_NUM-1:0]   e_en;
    logic [CHNL_NUM*2-1:0] e_prio;
    logic [CHNL_NUM*3-1:0] e_len;
    for (int ch = 0; ch < CHNL_NUM; ch++) begin
      e_en[ch]          = m_on[ch];
      e_prio[ch*2 +: 2] = 2'(m_out_prio[ch]);
      e_len[ch*3 +: 3]  = 3'(m_out_len[ch]);
    end
    check("model_chnl_en", 32'(chnl_en), 32'(e_en));
    check("model_chnl_prio", 32'(chnl_prio), 32'(e_prio));
    check("model_chnl_len", 32'(chnl_len), 32'(e_len));
    check("model_rdata", bus_if.cmd_data_o, m_rdata);
  endtask

  // One clock: model follows the DUT at the edge, outputs are checked on the
  // falling edge, inputs may change 1 time unit later.
  task automatic tick();
    @(posedge clk);
    if (rstn) model_step();
    @(negedge clk);
    compare_all();
    #1;
  endtask

  task automatic do_cmd(input logic [1:0] c, input logic [7:0] a, input logic [31:0] d);
    bus_if.cmd_i      = c;
    bus_if.cmd_addr_i = a;
    bus_if.cmd_data_i = d;
    tick();
    bus_if.cmd_i = CMD_IDLE;
    $display("txn cmd=%b addr=0x%02h data=0x%08h rdata=0x%08h en=%b", c, a, d,
             bus_if.cmd_data_o, chnl_en);
  endtask

  initial begin
    logic [1:0]  r_cmd;
    logic [7:0]  r_addr;
    logic [31:0] r_data;
    rstn = 1'b0;
    bus_if.cmd_i = CMD_IDLE; bus_if.cmd_addr_i = '0; bus_if.cmd_data_i = '0;
    slv_margin = '0; chnl_busy = '0;
    model_reset();
    tick(); tick();
    check("reset_en", 32'(chnl_en), 32'h0);
    check("reset_prio", 32'(chnl_prio), 32'h3F);
    check("reset_len", 32'(chnl_len), 32'h0);
    rstn = 1'b1;

    do_cmd(CMD_READ, 8'h00, 0);
    check("reset_ctrl0", bus_if.cmd_data_o, 32'h6);

    // Write/read channel 1
    do_cmd(CMD_WRITE, 8'h04, 32'h2B);
    check("wr_en1", 32'(chnl_en[1]), 32'h1);
    check("wr_prio1", 32'(chnl_prio[3:2]), 32'h1);
    check("wr_len1", 32'(chnl_len[5:3]), 32'h5);
    do_cmd(CMD_READ, 8'h04, 0);
    check("rd_ctrl1", bus_if.cmd_data_o, 32'h2B);

    // Config held while busy, applied once busy drops
    chnl_busy[1] = 1'b1;
    do_cmd(CMD_WRITE, 8'h04, 32'h1D);
    check("hold_prio1", 32'(chnl_prio[3:2]), 32'h1);
    check("hold_len1", 32'(chnl_len[5:3]), 32'h5);
    do_cmd(CMD_READ, 8'h04, 0);
    check("hold_rd_ctrl1", bus_if.cmd_data_o, 32'h1D);
    chnl_busy[1] = 1'b0;
    tick();
    check("apply_prio1", 32'(chnl_prio[3:2]), 32'h2);
    check("apply_len1", 32'(chnl_len[5:3]), 32'h3);

    // Drain channel 0
    chnl_busy[0] = 1'b1;
    do_cmd(CMD_WRITE, 8'h00, 32'h1);
    do_cmd(CMD_WRITE, 8'h00, 32'h0);
    check("drain_en0", 32'(chnl_en[0]), 32'h1);
    do_cmd(CMD_READ, 8'h10, 0);
    check("drain_stat0", bus_if.cmd_data_o, 32'h100);
    chnl_busy[0] = 1'b0;
    tick();
    check("drain_done_en0", 32'(chnl_en[0]), 32'h0);
    do_cmd(CMD_READ, 8'h10, 0);
    check("drain_done_stat0", bus_if.cmd_data_o, 32'h0);

    // Drain cancel
    chnl_busy[0] = 1'b1;
    do_cmd(CMD_WRITE, 8'h00, 32'h1);
    do_cmd(CMD_WRITE, 8'h00, 32'h0);
    check("cancel_pre_en0", 32'(chnl_en[0]), 32'h1);
    do_cmd(CMD_WRITE, 8'h00, 32'h1);
    check("cancel_en0", 32'(chnl_en[0]), 32'h1);
    do_cmd(CMD_READ, 8'h10, 0);
    check("cancel_stat0", bus_if.cmd_data_o, 32'h0);
    chnl_busy[0] = 1'b0;

    // Illegal writes change nothing
    do_cmd(CMD_WRITE, 8'h10, 32'hFFFF_FFFF);
    do_cmd(CMD_WRITE, 8'h0C, 32'hFFFF_FFFF);
    do_cmd(CMD_WRITE, 8'h02, 32'hFFFF_FFFF);
    do_cmd(CMD_READ, 8'h00, 0);
    check("illegal_ctrl0", bus_if.cmd_data_o, 32'h1);
    do_cmd(CMD_READ, 8'h04, 0);
    check("illegal_ctrl1", bus_if.cmd_data_o, 32'h1D);
    do_cmd(CMD_READ, 8'h08, 0);
    check("illegal_ctrl2", bus_if.cmd_data_o, 32'h6);
    do_cmd(CMD_READ, 8'h0C, 0);
    check("illegal_rd_0c", bus_if.cmd_data_o, 32'h0);

    // Status margin with saturation
    slv_margin = {8'h20, 8'h00, 8'h25};
    do_cmd(CMD_READ, 8'h18, 0);
    check("stat2_margin", bus_if.cmd_data_o, 32'h20);
    do_cmd(CMD_READ, 8'h10, 0);
    check("stat0_sat", bus_if.cmd_data_o, 32'h20);
    tick();
    check("rd_idle_zero", bus_if.cmd_data_o, 32'h0);

    // Reset in the middle of a drain
    chnl_busy[0] = 1'b1;
    do_cmd(CMD_WRITE, 8'h00, 32'h0);
    check("mid_drain_en0", 32'(chnl_en[0]), 32'h1);
    rstn = 1'b0;
    model_reset();
    tick();
    check("midrst_en", 32'(chnl_en), 32'h0);
    check("midrst_prio", 32'(chnl_prio), 32'h3F);
    check("midrst_len", 32'(chnl_len), 32'h0);
    rstn = 1'b1;
    do_cmd(CMD_READ, 8'h10, 0);
    check("midrst_stat0", bus_if.cmd_data_o, 32'h20);
    do_cmd(CMD_READ, 8'h00, 0);
    check("midrst_ctrl0", bus_if.cmd_data_o, 32'h6);
    chnl_busy = '0;

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        rstn = 1'b0;
        model_reset();
        tick();
        rstn = 1'b1;
      end
      r_cmd = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0, 1, 2: r_addr = 8'(4 * $urandom_range(0, 2));
        3, 4, 5: r_addr = 8'(16 + 4 * $urandom_range(0, 2));
        6:       r_addr = 8'h0C;
        7:       r_addr = 8'h1C;
        default: r_addr = 8'($urandom);
      endcase
      r_data = $urandom;
      if ($urandom_range(0, 3) != 0) chnl_busy = 3'($urandom);
      if ($urandom_range(0, 7) == 0) slv_margin = 24'($urandom);
      do_cmd(r_cmd, r_addr, r_data);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
